// File: rtl/adc_axis_framer.sv
// adc_axis_framer: ADC lane conversion, FIFO buffering and
// framed AXI4-Stream output in the m_axis_aclk domain.
module adc_axis_framer #(
  parameter int DATA_WIDTH = 14,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 256
) (
  input  logic                         m_axis_aclk,
  input  logic                         m_axis_aresetn,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
  input  logic                         s_valid,
  input  logic                         enable,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic                         offset_binary,
  input  logic                         ramp_mode,
  output logic [NUM_CH*16-1:0]         m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         busy,
  output logic [15:0]                  overflow_cnt,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(FRAME_LEN);
  localparam int OW = NUM_CH * 16;
  localparam int FW = OW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [FW-1:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [AW:0]           r_cnt;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic [OW-1:0]         r_tdata;
  logic [BW-1:0]         r_beat;
  logic [DATA_WIDTH-1:0] r_ramp;
  logic [15:0]           r_ovf;

  logic                  w_accept;
  logic                  w_start;
  logic                  w_full;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_load;
  logic                  w_last;
  logic [BW-1:0]         w_beat_nxt;
  logic [AW:0]           w_level;
  logic [OW-1:0]         w_lanes;
  logic [DATA_WIDTH-1:0] w_x;

  assign w_accept = s_valid &&
                    (r_state != S_IDLE);
  assign w_start  = (r_state == S_IDLE) &&
                    enable;

  // The output register counts as one FIFO entry.
  assign w_level = r_cnt + (AW+1)'(r_tvalid);
  assign w_full  = w_level == (AW+1)'(FIFO_DEPTH);
  assign w_rd    = r_tvalid && m_axis_tready;
  assign w_wr    = w_accept && (!w_full || w_rd);
  assign w_load  = (!r_tvalid || w_rd) &&
                   (r_cnt != '0);

  assign w_last = r_beat == BW'(FRAME_LEN - 1);

  // Frame position after this cycle's write, if any.
  always_comb begin
    w_beat_nxt = r_beat;
    if (w_wr) begin
      w_beat_nxt = w_last ? '0
                          : r_beat + BW'(1);
    end
  end

  // Per-lane conversion or ramp substitution, then masking.
  always_comb begin
    w_lanes = '0;
    w_x     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ramp_mode) begin
        w_x = r_ramp + DATA_WIDTH'(k);
      end else begin
        w_x = s_data[k*DATA_WIDTH +: DATA_WIDTH] ^
              {offset_binary,
               {(DATA_WIDTH-1){1'b0}}};
      end
      if (ch_enable[k]) begin
        w_lanes[k*16 +: 16] = 16'($signed(w_x));
      end
    end
  end

  // Next-state logic; a stop only leaves once the
  // frame in progress has been completed by writes.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (enable) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!enable) begin
          w_state_nxt = (w_beat_nxt != '0) ? S_STOP
                                           : S_IDLE;
        end
      end
      S_STOP: begin
        if (w_wr && w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) r_state <= S_IDLE;
    else                 r_state <= w_state_nxt;
  end

  // Beat and ramp counters advance only on real writes.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      r_beat <= '0;
      r_ramp <= '0;
    end else if (w_start) begin
      r_beat <= '0;
      r_ramp <= '0;
    end else if (w_wr) begin
      r_beat <= w_beat_nxt;
      r_ramp <= r_ramp + DATA_WIDTH'(1);
    end
  end

  // Saturating count of samples dropped on a full FIFO.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      r_ovf <= '0;
    end else if (w_accept && !w_wr &&
                 (r_ovf != 16'hFFFF)) begin
      r_ovf <= r_ovf + 16'd1;
    end
  end

  // FIFO storage; contents are invalidated via pointers.
  always_ff @(posedge m_axis_aclk) begin
    if (w_wr) r_mem[r_wptr] <= {w_last, w_lanes};
  end

  // FIFO pointers and registered fall-through output.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_load) begin
        r_rptr              <= r_rptr + AW'(1);
        {r_tlast, r_tdata}  <= r_mem[r_rptr];
        r_tvalid            <= 1'b1;
      end else if (w_rd) begin
        r_tvalid <= 1'b0;
      end
      r_cnt <= r_cnt + (AW+1)'(w_wr)
                     - (AW+1)'(w_load);
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign busy          = r_state != S_IDLE;
  assign overflow_cnt  = r_ovf;
  assign fifo_level    = w_level;

endmodule

// File: tb/tb_adc_axis_framer.sv
// tb_adc_axis_framer: directed bench for adc_axis_framer
// with DATA_WIDTH=14, NUM_CH=2, FIFO_DEPTH=16, FRAME_LEN=8.
module tb_adc_axis_framer;

  localparam int DW = 14;
  localparam int NC = 2;
  localparam int FD = 16;
  localparam int FL = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NC*DW-1:0] s_data = '0;
  logic           s_valid = 1'b0;
  logic           enable = 1'b0;
  logic [NC-1:0]  ch_enable = 2'b11;
  logic           offset_binary = 1'b0;
  logic           ramp_mode = 1'b0;
  logic [NC*16-1:0] tdata;
  logic           tvalid;
  logic           tready = 1'b0;
  logic           tlast;
  logic           busy;
  logic [15:0]    ovf;
  logic [4:0]     level;

  int checks = 0;
  int errors = 0;
  logic done = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  adc_axis_framer #(
    .DATA_WIDTH(DW),
    .NUM_CH    (NC),
    .FIFO_DEPTH(FD),
    .FRAME_LEN (FL)
  ) dut (
    .m_axis_aclk   (clk),
    .m_axis_aresetn(rst_n),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .enable        (enable),
    .ch_enable     (ch_enable),
    .offset_binary (offset_binary),
    .ramp_mode     (ramp_mode),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .busy          (busy),
    .overflow_cnt  (ovf),
    .fifo_level    (level)
  );

  initial begin
    #200000;
    if (!done) begin
      errors++;
      $error("FAIL timeout waiting for test end");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tdata", tdata, 32'h0);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", ovf, 16'h0);
    chk("rst_level", level, 5'd0);
    rst_n = 1'b1;
    @(negedge clk);

    ramp_mode = 1'b1;
    tready    = 1'b1;
    enable    = 1'b1;
    s_valid   = 1'b1;
    @(negedge clk);
    chk("ramp_busy", busy, 1'b1);
    chk("ramp_tv0", tvalid, 1'b0);
    @(negedge clk);
    chk("ramp_tv1", tvalid, 1'b0);
    chk("ramp_lvl1", level, 5'd1);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      chk($sformatf("ramp_v%0d", j), tvalid, 1'b1);
      chk($sformatf("ramp_d%0d", j), tdata,
          {16'(j), 16'(j - 1)});
      chk($sformatf("ramp_l%0d", j), tlast,
          (j % FL == 0));
      if (j == 15) begin
        s_valid = 1'b0;
        enable  = 1'b0;
      end
    end
    chk("ramp_idle", busy, 1'b0);
    @(negedge clk);
    chk("ramp_drain_tv", tvalid, 1'b0);
    chk("ramp_drain_lvl", level, 5'd0);

    ramp_mode     = 1'b0;
    offset_binary = 1'b1;
    ch_enable     = 2'b11;
    enable        = 1'b1;
    @(negedge clk);
    s_data  = {14'h0000, 14'h0000};
    s_valid = 1'b1;
    @(negedge clk);
    chk("ob_busy", busy, 1'b1);
    chk("ob_tv0", tvalid, 1'b0);
    s_data = {14'h0000, 14'h2000};
    @(negedge clk);
    chk("ob_0000", tdata, 32'hE000_E000);
    s_data = {14'h0000, 14'h3FFF};
    @(negedge clk);
    chk("ob_2000", tdata, 32'hE000_0000);
    enable        = 1'b0;
    offset_binary = 1'b0;
    ch_enable     = 2'b10;
    s_data        = {14'h2000, 14'h1FFF};
    @(negedge clk);
    chk("ob_3FFF", tdata, 32'hE000_1FFF);
    chk("stop_busy3", busy, 1'b1);
    for (int i = 4; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("mask_d%0d", i), tdata,
          32'hE000_0000);
      chk($sformatf("stop_l%0d", i), tlast,
          (i == 8));
      chk($sformatf("stop_busy%0d", i), busy,
          (i < 7));
    end
    repeat (4) @(negedge clk);
    chk("stop_no_wr_tv", tvalid, 1'b0);
    chk("stop_no_wr_lvl", level, 5'd0);
    chk("stop_no_busy", busy, 1'b0);
    s_valid   = 1'b0;
    ch_enable = 2'b11;

    ramp_mode = 1'b1;
    tready    = 1'b0;
    enable    = 1'b1;
    @(negedge clk);
    s_valid = 1'b1;
    repeat (20) @(negedge clk);
    s_valid = 1'b0;
    enable  = 1'b0;
    chk("ovf_level", level, 5'd16);
    chk("ovf_cnt", ovf, 16'd4);
    chk("ovf_head", tdata, 32'h0001_0000);
    repeat (2) @(negedge clk);
    chk("ovf_hold_d", tdata, 32'h0001_0000);
    chk("ovf_hold_v", tvalid, 1'b1);
    chk("ovf_idle", busy, 1'b0);
    tready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("ovf_v%0d", k), tvalid, 1'b1);
      chk($sformatf("ovf_d%0d", k), tdata,
          {16'(k + 1), 16'(k)});
      chk($sformatf("ovf_l%0d", k), tlast,
          (k % FL == FL - 1));
      @(negedge clk);
    end
    chk("ovf_end_tv", tvalid, 1'b0);
    chk("ovf_end_lvl", level, 5'd0);
    chk("ovf_keep", ovf, 16'd4);

    tready = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    s_valid = 1'b1;
    repeat (6) @(negedge clk);
    s_valid = 1'b0;
    chk("ar_pre_lvl", level, 5'd6);
    chk("ar_pre_tv", tvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_tv", tvalid, 1'b0);
    chk("ar_lvl", level, 5'd0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_ovf", ovf, 16'd0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    tready  = 1'b1;
    s_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ar_tv1", tvalid, 1'b0);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      chk($sformatf("ar_v%0d", j), tvalid, 1'b1);
      chk($sformatf("ar_d%0d", j), tdata,
          {16'(j), 16'(j - 1)});
      chk($sformatf("ar_l%0d", j), tlast,
          (j == 8));
      if (j == 7) begin
        s_valid = 1'b0;
        enable  = 1'b0;
      end
    end
    @(negedge clk);
    chk("ar_end_tv", tvalid, 1'b0);
    chk("ar_end_busy", busy, 1'b0);

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
